rrg_sequencer: RTL and testbench

RRG_SEQUENCER -- requirements
Module: rrg_sequencer

---
 rtl/rrg_pkg.sv | 35 +++
 rtl/rrg_seq_dwell_timer.sv | 29 ++
 rtl/rrg_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_rrg_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rrg_pkg.sv
// Shared definitions for the ramp-generator sequencer: command codes on the
// rrg_control bus, table field codes and the sequencer FSM state encoding.
package rrg_pkg;

    localparam logic [15:0] CMD_IDLE        = 16'h0000;
    localparam logic [15:0] CMD_WRITE_YSET  = 16'h0001;
    localparam logic [15:0] CMD_WRITE_RSET  = 16'h0002;
    localparam logic [15:0] CMD_WRITE_RISET = 16'h0003;
    localparam logic [15:0] CMD_WRITE_ROSET = 16'h0004;
    localparam logic [15:0] CMD_UPDATE      = 16'h0005;
    localparam logic [15:0] CMD_HALT        = 16'h0009;

    localparam logic [2:0] FLD_YSET  = 3'd0;
    localparam logic [2:0] FLD_RSET  = 3'd1;
    localparam logic [2:0] FLD_RISET = 3'd2;
    localparam logic [2:0] FLD_ROSET = 3'd3;
    localparam logic [2:0] FLD_DWELL = 3'd4;

    localparam int NR_FIELDS = 5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        GAP,
        DWELL,
        HALT,
        HALT_GAP
    } rrg_state_t;

    // Field f is written with command f+1; f=4 maps onto CMD_UPDATE.
    function automatic logic [15:0] cmd_for_field(input logic [2:0] fld);
        return CMD_WRITE_YSET + 16'(fld);
    endfunction

endpackage

// File: rtl/rrg_seq_dwell_timer.sv
// Dwell timer: loaded with the step's dwell count, counts down while the
// sequencer dwells, saturating at zero so a large count can never wrap.
// tc is high once the current cycle is the last dwell cycle, which makes a
// dwell of 0 behave like a dwell of 1.
module rrg_seq_dwell_timer (
    input  logic        clk_slow,
    input  logic        nReset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        count,
    output logic        tc
);

    logic [31:0] cnt;

    // Down-counter with load priority and saturation at zero.
    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            cnt <= 32'd0;
        end else if (load) begin
            cnt <= load_value;
        end else if (count && (cnt != 32'd0)) begin
            cnt <= cnt - 32'd1;
        end
    end

    assign tc = (cnt <= 32'd1);

endmodule

// File: rtl/rrg_sequencer.sv
// Ramp-generator sequencer: steps through a table of ramp settings, issuing
// the four field writes plus an update command per step (each followed by a
// one-cycle gap), then dwells before moving to the next step.
// Optional feature: define RRG_SEQ_LOOP_EN to allow continuous looping over
// the table when loop=1 at start.
module rrg_sequencer
    import rrg_pkg::*;
#(
    parameter int NR_STEPS = 8
) (
    input  logic        clk_slow,
    input  logic        nReset,
    input  logic        tbl_we,
    input  logic [7:0]  tbl_addr,
    input  logic [2:0]  tbl_field,
    input  logic [63:0] tbl_data,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  num_steps,
    input  logic        loop,
    output logic        busy,
    output logic [7:0]  step_idx,
    output logic        done,
    output logic [15:0] rrg_control,
    output logic [15:0] rrg_reg_0,
    output logic [15:0] rrg_reg_1,
    output logic [15:0] rrg_reg_2,
    output logic [15:0] rrg_reg_3
);

    localparam int IDX_W = (NR_STEPS > 1) ? $clog2(NR_STEPS) : 1;

    logic [63:0] tbl [NR_STEPS][NR_FIELDS];

    rrg_state_t  state, state_nxt;
    logic [2:0]  fld, fld_nxt, fld_inc;
    logic [7:0]  step_nxt, num_lat, num_nxt;
    logic        busy_nxt, done_nxt, last_step;
    logic [15:0] ctrl_nxt;
    logic [63:0] bus, bus_nxt;
    logic [63:0] dwell_word;
    logic        unused_dwell_hi;
    logic        tmr_load, tmr_count, tmr_tc;

`ifdef RRG_SEQ_LOOP_EN
    logic loop_lat, loop_nxt;
`else
    logic unused_loop;
    assign unused_loop = loop;
`endif

    // Out-of-range step indices read as zero rather than aliasing.
    function automatic logic [63:0] tbl_read(input logic [7:0] idx, input logic [2:0] f);
        logic [63:0] v;
        v = '0;
        if (({1'b0, idx} < 9'(NR_STEPS)) && (f < 3'(NR_FIELDS))) begin
            v = tbl[idx[IDX_W-1:0]][f];
        end
        return v;
    endfunction

    // Table write port: accepted in any state, never cleared by reset.
    always_ff @(posedge clk_slow) begin
        if (tbl_we && (tbl_field < 3'(NR_FIELDS)) && ({1'b0, tbl_addr} < 9'(NR_STEPS))) begin
            tbl[tbl_addr[IDX_W-1:0]][tbl_field] <= tbl_data;
        end
    end

    assign fld_inc         = fld + 3'd1;
    assign last_step       = (step_idx == (num_lat - 8'd1));
    assign dwell_word      = tbl_read(step_idx, FLD_DWELL);
    assign unused_dwell_hi = ^dwell_word[63:32];

    rrg_seq_dwell_timer u_dwell_timer (
        .clk_slow   (clk_slow),
        .nReset     (nReset),
        .load       (tmr_load),
        .load_value (dwell_word[31:0]),
        .count      (tmr_count),
        .tc         (tmr_tc)
    );

    // State, status and command-bus registers; reset leaves the table alone.
    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            state       <= IDLE;
            fld         <= FLD_YSET;
            step_idx    <= 8'd0;
            num_lat     <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rrg_control <= CMD_IDLE;
            bus         <= '0;
`ifdef RRG_SEQ_LOOP_EN
            loop_lat    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            fld         <= fld_nxt;
            step_idx    <= step_nxt;
            num_lat     <= num_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            rrg_control <= ctrl_nxt;
            bus         <= bus_nxt;
`ifdef RRG_SEQ_LOOP_EN
            loop_lat    <= loop_nxt;
`endif
        end
    end

    // Next-state and next-output logic; abort while running overrides all.
    always_comb begin
        state_nxt = state;
        fld_nxt   = fld;
        step_nxt  = step_idx;
        num_nxt   = num_lat;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        ctrl_nxt  = CMD_IDLE;
        bus_nxt   = bus;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
`ifdef RRG_SEQ_LOOP_EN
        loop_nxt  = loop_lat;
`endif
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (num_steps != 8'd0) begin
                        num_nxt   = num_steps;
                        step_nxt  = 8'd0;
                        busy_nxt  = 1'b1;
                        fld_nxt   = FLD_YSET;
                        state_nxt = CMD;
                        ctrl_nxt  = CMD_WRITE_YSET;
                        bus_nxt   = tbl_read(8'd0, FLD_YSET);
`ifdef RRG_SEQ_LOOP_EN
                        loop_nxt  = loop;
`endif
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            CMD: begin
                state_nxt = GAP;
            end
            GAP: begin
                if (fld == FLD_DWELL) begin
                    state_nxt = DWELL;
                    tmr_load  = 1'b1;
                end else begin
                    fld_nxt   = fld_inc;
                    state_nxt = CMD;
                    ctrl_nxt  = cmd_for_field(fld_inc);
                    bus_nxt   = (fld_inc == FLD_DWELL) ? 64'd0 : tbl_read(step_idx, fld_inc);
                end
            end
            DWELL: begin
                tmr_count = 1'b1;
                if (tmr_tc) begin
                    if (last_step) begin
`ifdef RRG_SEQ_LOOP_EN
                        if (loop_lat) begin
                            step_nxt  = 8'd0;
                            fld_nxt   = FLD_YSET;
                            state_nxt = CMD;
                            ctrl_nxt  = CMD_WRITE_YSET;
                            bus_nxt   = tbl_read(8'd0, FLD_YSET);
                        end else begin
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end
`else
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
`endif
                    end else begin
                        step_nxt  = step_idx + 8'd1;
                        fld_nxt   = FLD_YSET;
                        state_nxt = CMD;
                        ctrl_nxt  = CMD_WRITE_YSET;
                        bus_nxt   = tbl_read(step_idx + 8'd1, FLD_YSET);
                    end
                end
            end
            HALT: begin
                state_nxt = HALT_GAP;
            end
            HALT_GAP: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
        if (abort && ((state == CMD) || (state == GAP) || (state == DWELL))) begin
            state_nxt = HALT;
            fld_nxt   = fld;
            step_nxt  = step_idx;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b0;
            ctrl_nxt  = CMD_HALT;
            bus_nxt   = 64'd0;
            tmr_load  = 1'b0;
            tmr_count = 1'b0;
        end
    end

    assign rrg_reg_0 = bus[15:0];
    assign rrg_reg_1 = bus[31:16];
    assign rrg_reg_2 = bus[47:32];
    assign rrg_reg_3 = bus[63:48];

endmodule

// File: tb/tb_rrg_sequencer.sv
// Self-checking bench for rrg_sequencer. A trace model builds the expected
// per-cycle outputs of each run directly from the sequencing rules (five
// command/gap pairs, then max(dwell,1) dwell cycles per step, done at the end,
// halt sequence on abort) and every cycle is compared against the DUT.
module tb_rrg_sequencer;

    localparam int NR = 8;
`ifdef RRG_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic        clk_slow = 1'b0;
    logic        nReset = 1'b0;
    logic        tbl_we = 1'b0;
    logic [7:0]  tbl_addr = 8'd0;
    logic [2:0]  tbl_field = 3'd0;
    logic [63:0] tbl_data = 64'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_steps = 8'd0;
    logic        loop = 1'b0;
    logic        busy, done;
    logic [7:0]  step_idx;
    logic [15:0] rrg_control, rrg_reg_0, rrg_reg_1, rrg_reg_2, rrg_reg_3;
    logic [63:0] bus_obs;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] ctrl;
        logic [63:0] data;
        logic [7:0]  step;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mtbl [NR][5];
    logic [63:0] m_data = 64'd0;
    logic [7:0]  m_step = 8'd0;

    rrg_sequencer #(.NR_STEPS(NR)) dut (
        .clk_slow    (clk_slow),
        .nReset      (nReset),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_field   (tbl_field),
        .tbl_data    (tbl_data),
        .start       (start),
        .abort       (abort),
        .num_steps   (num_steps),
        .loop        (loop),
        .busy        (busy),
        .step_idx    (step_idx),
        .done        (done),
        .rrg_control (rrg_control),
        .rrg_reg_0   (rrg_reg_0),
        .rrg_reg_1   (rrg_reg_1),
        .rrg_reg_2   (rrg_reg_2),
        .rrg_reg_3   (rrg_reg_3)
    );

    assign bus_obs = {rrg_reg_3, rrg_reg_2, rrg_reg_1, rrg_reg_0};

    always #5 clk_slow = ~clk_slow;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic void pushExp(input logic [15:0] c, input logic [63:0] d,
                                    input logic [7:0] s, input logic b, input logic dn);
        exp_t e;
        e.ctrl = c; e.data = d; e.step = s; e.busy = b; e.done = dn;
        exp_q.push_back(e);
    endfunction

    // Expected trace, one entry per cycle after the start edge.
    task automatic buildExpected(input int num, input bit lp, input int abort_at);
        int          s;
        logic [31:0] dw;
        logic [63:0] fv;
        logic [7:0]  hstep;
        exp_q.delete();
        if (num == 0) begin
            pushExp(16'h0, m_data, m_step, 1'b0, 1'b1);
        end else begin
            s = 0;
            while (exp_q.size() < 4000) begin
                for (int f = 0; f < 5; f++) begin
                    fv = (f < 4) ? mtbl[s][f] : 64'd0;
                    pushExp(16'(f + 1), fv, 8'(s), 1'b1, 1'b0);
                    pushExp(16'h0, fv, 8'(s), 1'b1, 1'b0);
                end
                dw = mtbl[s][4][31:0];
                if (dw == 32'd0) dw = 32'd1;
                for (int i = 0; i < int'(dw); i++) pushExp(16'h0, 64'd0, 8'(s), 1'b1, 1'b0);
                s++;
                if (s == num) begin
                    if (!(lp && LOOP_EN)) break;
                    s = 0;
                    if (abort_at >= 0 && exp_q.size() > abort_at) break;
                end
            end
            pushExp(16'h0, 64'd0, 8'(num - 1), 1'b0, 1'b1);
            if (abort_at >= 1 && abort_at < exp_q.size() && exp_q[abort_at - 1].busy) begin
                hstep = exp_q[abort_at - 1].step;
                while (exp_q.size() > abort_at) void'(exp_q.pop_back());
                pushExp(16'h0009, 64'd0, hstep, 1'b1, 1'b0);
                pushExp(16'h0000, 64'd0, hstep, 1'b1, 1'b0);
                pushExp(16'h0000, 64'd0, hstep, 1'b0, 1'b1);
            end
            m_data = 64'd0;
            m_step = exp_q[exp_q.size() - 1].step;
        end
        pushExp(16'h0, m_data, m_step, 1'b0, 1'b0);
        pushExp(16'h0, m_data, m_step, 1'b0, 1'b0);
    endtask

    task automatic writeTable(input logic [7:0] a, input logic [2:0] f, input logic [63:0] d);
        tbl_we = 1'b1; tbl_addr = a; tbl_field = f; tbl_data = d;
        @(posedge clk_slow); #1;
        tbl_we = 1'b0;
        if (f < 3'd5 && a < 8'(NR)) mtbl[a[2:0]][f] = d;
    endtask

    task automatic checkAll(input string tag, input exp_t e);
        checkOutput({tag, " ctrl"}, 64'(rrg_control), 64'(e.ctrl));
        checkOutput({tag, " data"}, bus_obs, e.data);
        checkOutput({tag, " step"}, 64'(step_idx), 64'(e.step));
        checkOutput({tag, " busy"}, 64'(busy), 64'(e.busy));
        checkOutput({tag, " done"}, 64'(done), 64'(e.done));
    endtask

    // Start a run and compare every cycle; noisy adds ignored start/abort/num_steps activity.
    task automatic applyStimulus(input string name, input int num, input bit lp,
                                 input int abort_at, input bit noisy);
        buildExpected(num, lp, abort_at);
        start = 1'b1; num_steps = 8'(num); loop = lp;
        @(posedge clk_slow); #1;
        start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            checkAll($sformatf("%s[%0d]", name, k), exp_q[k]);
            abort = (k + 1 == abort_at) || (noisy && !exp_q[k].busy && ($urandom_range(0, 1) == 1));
            start = noisy && exp_q[k].busy && ($urandom_range(0, 3) == 0);
            if (noisy) begin
                num_steps = 8'($urandom_range(0, 255));
                loop      = 1'($urandom_range(0, 1));
            end
            @(posedge clk_slow); #1;
        end
        abort = 1'b0; start = 1'b0; loop = 1'b0;
    endtask

    task automatic loadStep(input int s, input logic [63:0] y, input logic [63:0] r,
                            input logic [63:0] ri, input logic [63:0] ro, input logic [31:0] dw);
        writeTable(8'(s), 3'd0, y);
        writeTable(8'(s), 3'd1, r);
        writeTable(8'(s), 3'd2, ri);
        writeTable(8'(s), 3'd3, ro);
        writeTable(8'(s), 3'd4, {$urandom, dw});
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        exp_t zero_e;
        int   num, abort_at;
        bit   lp;
        zero_e = '0;
        for (int s = 0; s < NR; s++) for (int f = 0; f < 5; f++) mtbl[s][f] = 64'd0;
        for (int s = 0; s < NR; s++) for (int f = 0; f < 5; f++) writeTable(8'(s), 3'(f), 64'd0);

        // Reset state
        nReset = 1'b0;
        repeat (2) @(posedge clk_slow);
        #1;
        checkAll("reset", zero_e);
        nReset = 1'b1;

        // Basic single-step run, plus writes that must be ignored
        loadStep(0, 64'h4000_0000_0000_0000, 64'h100, 64'h10, 64'h10, 32'd3);
        writeTable(8'd0, 3'd5, rnd64());
        writeTable(8'd0, 3'd7, rnd64());
        writeTable(8'(NR), 3'd0, rnd64());
        writeTable(8'd255, 3'd1, rnd64());
        applyStimulus("single", 1, 1'b0, -1, 1'b0);

        // Three steps with dwell 0/1/5
        mtbl[0][4] = 64'd0; writeTable(8'd0, 3'd4, 64'd0);
        loadStep(1, rnd64(), rnd64(), rnd64(), rnd64(), 32'd1);
        loadStep(2, rnd64(), rnd64(), rnd64(), rnd64(), 32'd5);
        applyStimulus("three", 3, 1'b0, -1, 1'b1);

        // Abort on the first dwell cycle of step 1 (step 0 dwell 2)
        writeTable(8'd0, 3'd4, 64'd2);
        writeTable(8'd1, 3'd4, 64'd4);
        applyStimulus("abort", 3, 1'b0, 23, 1'b0);

        // Zero-step start: done only
        applyStimulus("zero", 0, 1'b0, -1, 1'b0);

        // abort together with start in IDLE: start ignored
        abort = 1'b1; start = 1'b1; num_steps = 8'd2;
        @(posedge clk_slow); #1;
        abort = 1'b0; start = 1'b0;
        checkOutput("abort_start busy", 64'(busy), 64'd0);
        checkOutput("abort_start ctrl", 64'(rrg_control), 64'd0);
        @(posedge clk_slow); #1;
        checkOutput("abort_start done", 64'(done), 64'd0);
        checkOutput("abort_start busy2", 64'(busy), 64'd0);

        // Loop request over two steps; only the looping build needs the abort
        writeTable(8'd0, 3'd4, 64'd1);
        writeTable(8'd1, 3'd4, 64'd2);
        abort_at = LOOP_EN ? 60 : -1;
        applyStimulus("loop", 2, 1'b1, abort_at, 1'b0);

        // Randomized runs
        for (int it = 0; it < 8; it++) begin
            for (int s = 0; s < 4; s++)
                loadStep(s, rnd64(), rnd64(), rnd64(), rnd64(), 32'($urandom_range(0, 6)));
            num = $urandom_range(1, 4);
            lp  = 1'($urandom_range(0, 1));
            abort_at = -1;
            if ((LOOP_EN && lp) || ($urandom_range(0, 1) == 1)) abort_at = $urandom_range(1, 10 * num);
            applyStimulus($sformatf("rand%0d", it), num, lp, abort_at, 1'b1);
        end

        // Reset during GAP: outputs clear, no halt command, table retained
        loadStep(0, 64'h4000_0000_0000_0000, 64'h100, 64'h10, 64'h10, 32'd3);
        start = 1'b1; num_steps = 8'd1;
        @(posedge clk_slow); #1;
        start = 1'b0;
        checkOutput("pre_rst cmd", 64'(rrg_control), 64'h1);
        @(posedge clk_slow); #1;
        checkOutput("pre_rst gap", 64'(rrg_control), 64'h0);
        checkOutput("pre_rst data", bus_obs, 64'h4000_0000_0000_0000);
        nReset = 1'b0;
        @(posedge clk_slow); #1;
        nReset = 1'b1;
        checkAll("mid_rst", zero_e);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_slow); #1;
            checkAll($sformatf("post_rst[%0d]", i), zero_e);
        end
        m_data = 64'd0; m_step = 8'd0;
        applyStimulus("rerun", 1, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
